// File: rtl/ctrl_pkg.sv
// Shared encodings and the per-instruction control bundle for the decode-stage control pipe.
package ctrl_pkg;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_PC  = 2'b10;

    localparam logic [1:0] DST_RT  = 2'b00;
    localparam logic [1:0] DST_RD  = 2'b01;
    localparam logic [1:0] DST_RA  = 2'b10;

    localparam int RA_REG = 31;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_to_reg;
        logic [2:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/ctrl_pipe_hazard_unit.sv
// Hazard detection and EX operand forwarding selects.
// With FORWARD_EN defined, only load-use stalls; otherwise any in-flight EX/MEM writer stalls.
module hazard_unit
    import ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
`ifndef FORWARD_EN
    input  logic             ex_reg_write,
`endif
    input  logic [REG_W-1:0] ex_dst,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] mem_dst,
`ifdef FORWARD_EN
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             wb_reg_write,
    input  logic [REG_W-1:0] wb_dst,
`endif
    output logic             stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);

    // r0 is hard-wired zero, so it never creates a dependency
    function automatic logic src_hit(input logic [REG_W-1:0] dst,
                                     input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rt,
                                     input logic             uses_rt);
        return (dst != '0) && ((dst == rs) || (uses_rt && (dst == rt)));
    endfunction

    logic load_use;

    always_comb begin
        load_use = ex_mem_read && src_hit(ex_dst, id_rs, id_rt, id_uses_rt);
`ifdef FORWARD_EN
        stall = load_use;
`else
        stall = load_use
              || (ex_reg_write  && src_hit(ex_dst,  id_rs, id_rt, id_uses_rt))
              || (mem_reg_write && src_hit(mem_dst, id_rs, id_rt, id_uses_rt));
`endif
    end

`ifdef FORWARD_EN
    // EX/MEM result is younger than MEM/WB, so it wins
    function automatic logic [1:0] fwd_pick(input logic [REG_W-1:0] src);
        if (mem_reg_write && (mem_dst != '0) && (mem_dst == src))
            return FWD_MEM;
        else if (wb_reg_write && (wb_dst != '0) && (wb_dst == src))
            return FWD_WB;
        else
            return FWD_REG;
    endfunction

    always_comb begin
        fwd_a = fwd_pick(ex_rs);
        fwd_b = fwd_pick(ex_rt);
    end
`else
    assign fwd_a = FWD_REG;
    assign fwd_b = FWD_REG;
`endif

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM, MEM/WB control registers, destination select, stall/flush and stall counter.
// Optional operand forwarding is enabled by defining FORWARD_EN.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_reg_write,
    input  logic             id_alu_src,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic [1:0]       id_mem_to_reg,
    input  logic [1:0]       id_reg_dst,
    input  logic [2:0]       id_alu_op,
    input  logic             id_if_flush,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_uses_rt,
    output logic             ex_reg_write,
    output logic             ex_alu_src,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic [1:0]       ex_mem_to_reg,
    output logic [2:0]       ex_alu_op,
    output logic [REG_W-1:0] ex_dst,
    output logic [REG_W-1:0] mem_dst,
    output logic [REG_W-1:0] wb_dst,
    output logic             mem_reg_write,
    output logic             mem_mem_read,
    output logic             mem_mem_write,
    output logic [1:0]       mem_mem_to_reg,
    output logic             wb_reg_write,
    output logic [1:0]       wb_mem_to_reg,
    output logic             stall,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    ctrl_t            id_ctrl, ex_ctrl_d, ex_ctrl_q;
    logic [REG_W-1:0] dst_id;
    logic [REG_W-1:0] ex_dst_d, ex_dst_q;
    logic             mem_reg_write_d, mem_reg_write_q;
    logic             mem_mem_read_d, mem_mem_read_q;
    logic             mem_mem_write_d, mem_mem_write_q;
    logic [1:0]       mem_mem_to_reg_d, mem_mem_to_reg_q;
    logic [REG_W-1:0] mem_dst_d, mem_dst_q;
    logic             wb_reg_write_d, wb_reg_write_q;
    logic [1:0]       wb_mem_to_reg_d, wb_mem_to_reg_q;
    logic [REG_W-1:0] wb_dst_d, wb_dst_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
`ifdef FORWARD_EN
    logic [REG_W-1:0] ex_rs_d, ex_rs_q, ex_rt_d, ex_rt_q;
`endif

    always_comb begin
        id_ctrl = '{reg_write:  id_reg_write,
                    alu_src:    id_alu_src,
                    mem_read:   id_mem_read,
                    mem_write:  id_mem_write,
                    mem_to_reg: id_mem_to_reg,
                    alu_op:     id_alu_op};
        case (id_reg_dst)
            DST_RT:  dst_id = id_rt;
            DST_RD:  dst_id = id_rd;
            DST_RA:  dst_id = REG_W'(RA_REG);
            default: dst_id = '0;
        endcase
    end

    always_comb begin
        // a stall inserts a bubble; the instruction itself stays in ID
        ex_ctrl_d        = stall ? '0 : id_ctrl;
        ex_dst_d         = stall ? '0 : dst_id;
`ifdef FORWARD_EN
        ex_rs_d          = stall ? '0 : id_rs;
        ex_rt_d          = stall ? '0 : id_rt;
`endif
        mem_reg_write_d  = ex_ctrl_q.reg_write;
        mem_mem_read_d   = ex_ctrl_q.mem_read;
        mem_mem_write_d  = ex_ctrl_q.mem_write;
        mem_mem_to_reg_d = ex_ctrl_q.mem_to_reg;
        mem_dst_d        = ex_dst_q;
        wb_reg_write_d   = mem_reg_write_q;
        wb_mem_to_reg_d  = mem_mem_to_reg_q;
        wb_dst_d         = mem_dst_q;
        stall_cnt_d      = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_ctrl_q        <= '0;
            ex_dst_q         <= '0;
`ifdef FORWARD_EN
            ex_rs_q          <= '0;
            ex_rt_q          <= '0;
`endif
            mem_reg_write_q  <= 1'b0;
            mem_mem_read_q   <= 1'b0;
            mem_mem_write_q  <= 1'b0;
            mem_mem_to_reg_q <= '0;
            mem_dst_q        <= '0;
            wb_reg_write_q   <= 1'b0;
            wb_mem_to_reg_q  <= '0;
            wb_dst_q         <= '0;
            stall_cnt_q      <= '0;
        end else begin
            ex_ctrl_q        <= ex_ctrl_d;
            ex_dst_q         <= ex_dst_d;
`ifdef FORWARD_EN
            ex_rs_q          <= ex_rs_d;
            ex_rt_q          <= ex_rt_d;
`endif
            mem_reg_write_q  <= mem_reg_write_d;
            mem_mem_read_q   <= mem_mem_read_d;
            mem_mem_write_q  <= mem_mem_write_d;
            mem_mem_to_reg_q <= mem_mem_to_reg_d;
            mem_dst_q        <= mem_dst_d;
            wb_reg_write_q   <= wb_reg_write_d;
            wb_mem_to_reg_q  <= wb_mem_to_reg_d;
            wb_dst_q         <= wb_dst_d;
            stall_cnt_q      <= stall_cnt_d;
        end
    end

    hazard_unit #(.REG_W(REG_W)) u_hazard (
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .ex_mem_read   (ex_ctrl_q.mem_read),
`ifndef FORWARD_EN
        .ex_reg_write  (ex_ctrl_q.reg_write),
`endif
        .ex_dst        (ex_dst_q),
        .mem_reg_write (mem_reg_write_q),
        .mem_dst       (mem_dst_q),
`ifdef FORWARD_EN
        .ex_rs         (ex_rs_q),
        .ex_rt         (ex_rt_q),
        .wb_reg_write  (wb_reg_write_q),
        .wb_dst        (wb_dst_q),
`endif
        .stall         (stall),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b)
    );

    assign ex_reg_write   = ex_ctrl_q.reg_write;
    assign ex_alu_src     = ex_ctrl_q.alu_src;
    assign ex_mem_read    = ex_ctrl_q.mem_read;
    assign ex_mem_write   = ex_ctrl_q.mem_write;
    assign ex_mem_to_reg  = ex_ctrl_q.mem_to_reg;
    assign ex_alu_op      = ex_ctrl_q.alu_op;
    assign ex_dst         = ex_dst_q;
    assign mem_reg_write  = mem_reg_write_q;
    assign mem_mem_read   = mem_mem_read_q;
    assign mem_mem_write  = mem_mem_write_q;
    assign mem_mem_to_reg = mem_mem_to_reg_q;
    assign mem_dst        = mem_dst_q;
    assign wb_reg_write   = wb_reg_write_q;
    assign wb_mem_to_reg  = wb_mem_to_reg_q;
    assign wb_dst         = wb_dst_q;
    assign pc_write       = ~stall;
    assign if_id_write    = ~stall;
    assign if_id_flush    = id_if_flush & ~stall;
    assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: an instruction-history model predicts every output each cycle.
module tb_ctrl_pipe;

    localparam int CNT_W = 8;
    localparam int MAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic id_reg_write, id_alu_src, id_mem_read, id_mem_write, id_if_flush, id_uses_rt;
    logic [1:0] id_mem_to_reg, id_reg_dst;
    logic [2:0] id_alu_op;
    logic [4:0] id_rs, id_rt, id_rd;
    logic ex_reg_write, ex_alu_src, ex_mem_read, ex_mem_write;
    logic [1:0] ex_mem_to_reg;
    logic [2:0] ex_alu_op;
    logic [4:0] ex_dst, mem_dst, wb_dst;
    logic mem_reg_write, mem_mem_read, mem_mem_write, wb_reg_write;
    logic [1:0] mem_mem_to_reg, wb_mem_to_reg;
    logic stall, pc_write, if_id_write, if_id_flush;
    logic [1:0] fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt;

    ctrl_pipe #(.REG_W(5), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_reg_write(id_reg_write), .id_alu_src(id_alu_src), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_reg_dst(id_reg_dst),
        .id_alu_op(id_alu_op), .id_if_flush(id_if_flush), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .ex_reg_write(ex_reg_write), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_op(ex_alu_op),
        .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_mem_to_reg(mem_mem_to_reg), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .stall(stall), .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rw, src, mr, mw, urt, flush;
        bit [1:0] mtr, rdst;
        bit [2:0] op;
        bit [4:0] rs, rt, rd;
    } ins_t;

    typedef struct {
        bit rw, src, mr, mw;
        bit [1:0] mtr;
        bit [2:0] op;
        bit [4:0] dst, rs, rt;
    } stg_t;

    typedef struct {
        stg_t ex, mem, wb;
        bit stall, flush;
        bit [1:0] fa, fb;
        int cnt;
    } exp_t;

    // h[0] = instruction now in EX, h[1] in MEM, h[2] in WB
    stg_t h[3];
    int   cnt;
    exp_t q[$];
    int   n_chk = 0, n_err = 0;
    ins_t prev_i;
    bit   prev_stall;
    bit   have_prev;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ins_t mk(bit rw, bit src, bit mr, bit mw, bit [1:0] mtr, bit [1:0] rdst,
                                bit [2:0] op, bit [4:0] rs, bit [4:0] rt, bit [4:0] rd,
                                bit urt, bit flush);
        ins_t i;
        i.rw = rw; i.src = src; i.mr = mr; i.mw = mw; i.mtr = mtr; i.rdst = rdst;
        i.op = op; i.rs = rs; i.rt = rt; i.rd = rd; i.urt = urt; i.flush = flush;
        return i;
    endfunction

    function automatic bit [4:0] dst_of(ins_t i);
        case (i.rdst)
            2'd0: return i.rt;
            2'd1: return i.rd;
            2'd2: return 5'd31;
            default: return 5'd0;
        endcase
    endfunction

    function automatic bit reads(bit [4:0] d, ins_t i);
        return d != 0 && (d == i.rs || (i.urt && d == i.rt));
    endfunction

`ifdef FORWARD_EN
    function automatic bit [1:0] fsel(bit [4:0] r);
        if (h[1].rw && h[1].dst != 0 && h[1].dst == r) return 2'b10;
        if (h[2].rw && h[2].dst != 0 && h[2].dst == r) return 2'b01;
        return 2'b00;
    endfunction
`endif

    function automatic exp_t model(ins_t i);
        exp_t e;
        bit st;
        e.ex = h[0]; e.mem = h[1]; e.wb = h[2];
        st = h[0].mr && reads(h[0].dst, i);
`ifdef FORWARD_EN
        e.fa = fsel(h[0].rs);
        e.fb = fsel(h[0].rt);
`else
        for (int k = 0; k < 2; k++)
            if (h[k].rw && reads(h[k].dst, i)) st = 1;
        e.fa = 0;
        e.fb = 0;
`endif
        e.stall = st;
        e.flush = i.flush && !st;
        e.cnt = cnt;
        return e;
    endfunction

    task automatic advance(input ins_t i, input bit st);
        stg_t s = '{default: 0};
        if (!st) begin
            s.rw = i.rw; s.src = i.src; s.mr = i.mr; s.mw = i.mw;
            s.mtr = i.mtr; s.op = i.op; s.dst = dst_of(i); s.rs = i.rs; s.rt = i.rt;
        end
        h[2] = h[1]; h[1] = h[0]; h[0] = s;
        if (st && cnt < MAX) cnt++;
    endtask

    task automatic drive(input ins_t i);
        id_reg_write = i.rw; id_alu_src = i.src; id_mem_read = i.mr; id_mem_write = i.mw;
        id_mem_to_reg = i.mtr; id_reg_dst = i.rdst; id_alu_op = i.op; id_if_flush = i.flush;
        id_rs = i.rs; id_rt = i.rt; id_rd = i.rd; id_uses_rt = i.urt;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 3; k++) h[k] = '{default: 0};
        cnt = 0;
        prev_i = '{default: 0};
        prev_stall = 0;
        have_prev = 1;
    endtask

    task automatic step(input ins_t i);
        exp_t e;
        @(posedge clk);
        if (have_prev) advance(prev_i, prev_stall);
        #1;
        drive(i);
        e = model(i);
        q.push_back(e);
        prev_i = i;
        prev_stall = e.stall;
    endtask

    // a stalled instruction is re-presented in ID until it issues
    task automatic issue(input ins_t i);
        step(i);
        while (prev_stall) step(i);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_stages"}, {ex_reg_write, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                               ex_alu_op, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg,
                               wb_reg_write, wb_mem_to_reg}, 0);
        chk({tag, "_dsts"}, {ex_dst, mem_dst, wb_dst}, 0);
        chk({tag, "_stall"}, {stall, pc_write, if_id_write}, 3'b011);
        chk({tag, "_fwd"}, {fwd_a, fwd_b}, 0);
        chk({tag, "_cnt"}, stall_cnt, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1;
        drive('{default: 0});
        #1;
        chk_reset_state("rst_mid");
        @(posedge clk);
        #1;
        rst = 0;
        clear_model();
    endtask

    function automatic ins_t rnd();
        ins_t r;
        r.rw = 1'($urandom_range(0, 1)); r.src = 1'($urandom_range(0, 1));
        r.mr = 1'($urandom_range(0, 1)); r.mw = 1'($urandom_range(0, 1));
        r.mtr = 2'($urandom_range(0, 3)); r.rdst = 2'($urandom_range(0, 3));
        r.op = 3'($urandom_range(0, 7));
        r.rs = 5'($urandom_range(0, 7)); r.rt = 5'($urandom_range(0, 7));
        r.rd = 5'($urandom_range(0, 7));
        r.urt = 1'($urandom_range(0, 1)); r.flush = ($urandom_range(0, 7) == 0);
        return r;
    endfunction

    // monitor: every cycle the DUT presents a full set of outputs
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ex_ctrl", {ex_reg_write, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_op},
                    {e.ex.rw, e.ex.src, e.ex.mr, e.ex.mw, e.ex.mtr, e.ex.op});
                chk("ex_dst", ex_dst, e.ex.dst);
                chk("mem_ctrl", {mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg},
                    {e.mem.rw, e.mem.mr, e.mem.mw, e.mem.mtr});
                chk("mem_dst", mem_dst, e.mem.dst);
                chk("wb_ctrl", {wb_reg_write, wb_mem_to_reg}, {e.wb.rw, e.wb.mtr});
                chk("wb_dst", wb_dst, e.wb.dst);
                chk("stall", stall, e.stall);
                chk("pc_ifid_write", {pc_write, if_id_write}, {!e.stall, !e.stall});
                chk("if_id_flush", if_id_flush, e.flush);
                chk("fwd", {fwd_a, fwd_b}, {e.fa, e.fb});
                chk("stall_cnt", stall_cnt, e.cnt);
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        n_err++;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1);
    end

    initial begin
        ins_t nop, lw8, add9, beq8;
        nop  = '{default: 0};
        lw8  = mk(1, 1, 1, 0, 2'b01, 2'b00, 3'd0, 5'd1, 5'd8, 5'd0, 0, 0);
        add9 = mk(1, 0, 0, 0, 2'b00, 2'b01, 3'd2, 5'd8, 5'd2, 5'd9, 1, 0);
        beq8 = mk(0, 0, 0, 0, 2'b00, 2'b00, 3'd1, 5'd8, 5'd2, 5'd0, 1, 1);

        rst = 1;
        drive(nop);
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("rst_init");
        rst = 0;
        clear_model();

        // load-use
        issue(lw8); issue(add9);
        repeat (3) issue(nop);
        // add r3,r1,r2 ; sub r4,r3,r3 ; and r6,r3,r5
        issue(mk(1, 0, 0, 0, 2'b00, 2'b01, 3'd2, 5'd1, 5'd2, 5'd3, 1, 0));
        issue(mk(1, 0, 0, 0, 2'b00, 2'b01, 3'd6, 5'd3, 5'd3, 5'd4, 1, 0));
        issue(mk(1, 0, 0, 0, 2'b00, 2'b01, 3'd0, 5'd3, 5'd5, 5'd6, 1, 0));
        repeat (3) issue(nop);
        // addi r0,r1,5 then add r5,r0,r0
        issue(mk(1, 1, 0, 0, 2'b00, 2'b00, 3'd2, 5'd1, 5'd0, 5'd0, 0, 0));
        issue(mk(1, 0, 0, 0, 2'b00, 2'b01, 3'd2, 5'd0, 5'd0, 5'd5, 1, 0));
        repeat (2) issue(nop);
        // jal
        issue(mk(1, 0, 0, 0, 2'b10, 2'b10, 3'd0, 5'd0, 5'd0, 5'd0, 0, 1));
        repeat (3) issue(nop);
        // flush request coincident with a load-use stall
        issue(lw8); issue(beq8);
        repeat (3) issue(nop);

        for (int n = 0; n < 800; n++) issue(rnd());
        do_reset();
        for (int n = 0; n < 300; n++) issue(rnd());
        // dense load-use to drive the counter into saturation
        for (int n = 0; n < 300; n++) begin
            issue(lw8);
            issue(add9);
        end
        issue(nop);

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("sb_drain", q.size(), 0);
        chk("cnt_sat", stall_cnt, MAX);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
